pe_input_buffer: RTL
====================

Name: pe_input_buffer

Overview:
- FIFO stage directly downstream of one multicast controller; one instance per PE.
- Captures every word the controller forwards (target_enable/output_value) and presents it to the PE datapath over a valid/ready interface.
- Drives the controller's target_ready with its not-full status, so the multicast bus stalls when the PE falls behind.

Parameters:
- BITWIDTH, 16, data word width; matches the multicast bus data width.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), derived; not overridden by instantiators.

Ports:
- clk  input  1  rising-edge clock.
- rstb  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of buffer contents.
- in_enable  input  1  from controller target_enable; push request.
- in_ready  output  1  to controller target_ready; high when not full.
- in_data  input  BITWIDTH  from controller output_value.
- out_valid  output  1  head entry available to PE.
- out_ready  input  1  PE accepts head entry.
- out_data  output  BITWIDTH  head entry (first-word fall-through).
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: push attempted while full.

Behaviour:
- Reset (rstb low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; overflow goes to 0.
  - Outputs: in_ready=1, out_valid=0, count=0, overflow=0.
  - out_data is don't-care while out_valid=0.
  - Storage array is not reset.
- Pointers:
  - PTR_W+1 bits each; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low PTR_W bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- in_ready = !full:
  - Purely combinational from registered state.
  - No same-cycle pass-through: a pop in the current cycle does not raise in_ready in that cycle.
- Push:
  - Occurs when in_enable && !full.
  - Writes in_data to mem[wr_ptr[PTR_W-1:0]] and increments wr_ptr.
- Push while full (in_enable && full):
  - Word is dropped.
  - Pointers are unchanged.
  - overflow sets on the next edge and stays set until reset or flush.
- Output side:
  - out_valid = !empty.
  - out_data = mem[rd_ptr[PTR_W-1:0]], combinational read.
- Pop: when out_valid && out_ready, increment rd_ptr. out_ready while empty has no effect.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N, i.e. in cycle N+1. No empty bypass.
- Simultaneous push and pop:
  - When neither full nor empty, both occur and count is unchanged.
  - When empty, only the push occurs.
  - When full, only the pop occurs; the push is blocked by in_ready=0.
- count: registered; +1 on push only, -1 on pop only, unchanged otherwise.
- flush:
  - Takes priority over push and pop in the same cycle.
  - Next state: pointers=0, count=0, overflow=0.
  - Any push in that cycle is discarded without setting overflow.
- Reset mid-operation: all contents are lost immediately; no partial-state retention.

Optional Feature:
- Macro: PE_INPUT_BUFFER_STATS_EN.
- Defined:
  - Adds output accept_count [31:0], incremented on every successful push.
  - Adds output drop_count [15:0], incremented on every dropped push; saturates at 16'hFFFF.
  - Both clear on reset and on flush.
  - accept_count wraps modulo 2^32.
- Undefined: neither port nor its counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package nn_bus_pkg:
  - BUS_BITWIDTH default (16).
  - Tag ADDRESS_WIDTH default (4).
  - clog2 helper function.
  - Typedef for a bus word.
- One sub-module, pe_input_buffer_mem:
  - DEPTH x BITWIDTH register array.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset then idle: check in_ready=1, out_valid=0, count=0, overflow=0. Assert rstb low mid-stream with count=3 -> all return to reset values immediately, without waiting for a clock edge.
- Push 16'h0001..16'h0004 on consecutive cycles with out_ready=0 (DEPTH=4):
  - count steps 1..4.
  - in_ready drops in the cycle after the 4th push.
  - out_data=16'h0001.
- With the buffer full, hold in_enable=1 and in_data=16'hDEAD for 1 cycle:
  - overflow=1 and count stays 4.
  - Draining yields 0001,0002,0003,0004; DEAD never appears.
- Streaming with in_enable=1 and out_ready=1 continuously for 10 words:
  - count holds at 1 after the first cycle.
  - Output order matches input order.
  - Pointers wrap twice without error.
- With count=2, assert flush together with in_enable=1 and out_ready=1 -> next cycle count=0, out_valid=0, overflow=0, and the pushed word is absent.
- With STATS_EN defined: 6 pushes into an empty DEPTH=4 buffer with no pops -> accept_count=4, drop_count=2. Then flush -> both counters read 0.

Source files
------------

// File: rtl/nn_bus_pkg.sv
// Shared multicast-bus definitions: bus width, tag address width, word type and a clog2 helper.
// No logic or latency; package only.
// No flow control here; consumed by the bus endpoints.
package nn_bus_pkg;

  localparam int BUS_BITWIDTH  = 16;
  localparam int ADDRESS_WIDTH = 4;

  typedef logic [BUS_BITWIDTH-1:0] bus_word_t;

  // Ceiling log2 evaluated at elaboration; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_input_buffer_mem.sv
// DEPTH x BITWIDTH register array: one synchronous write port and one asynchronous read port.
// Write lands on the clock edge; read data follows raddr combinationally.
// No flow control; the owner gates we.
module pe_input_buffer_mem #(
  parameter int BITWIDTH = 16,
  parameter int DEPTH    = 4,
  parameter int AW       = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [BITWIDTH-1:0] rdata
);

  // Storage is intentionally not reset; validity is tracked by the owner's pointers.
  logic [BITWIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pe_input_buffer.sv
// Per-PE input FIFO behind a multicast controller; first-word fall-through valid/ready output.
// Latency: a word pushed on edge N is presented in cycle N+1 (no empty bypass).
// Backpressure: in_ready = !full from registered state only; pushes while full are dropped and flagged.
// Optional statistics counters are enabled with the PE_INPUT_BUFFER_STATS_EN macro.
module pe_input_buffer
  import nn_bus_pkg::*;
#(
  parameter int BITWIDTH = BUS_BITWIDTH,
  parameter int DEPTH    = 4,
  parameter int PTR_W    = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                flush,
  input  logic                in_enable,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic [PTR_W:0]      count,
  output logic                overflow
`ifdef PE_INPUT_BUFFER_STATS_EN
  ,
  output logic [31:0]         accept_count,
  output logic [15:0]         drop_count
`endif
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic           overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push;
  logic drop;
  logic pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  // A pop in this cycle never frees space for a push in the same cycle.
  assign push = in_enable && !full;
  assign drop = in_enable && full;
  assign pop  = !empty && out_ready;

  // Next-state for pointers, occupancy and the sticky overflow flag; flush wins over everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + PTR_ONE;
      end else if (pop && !push) begin
        count_d = count_q - PTR_ONE;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers; reset clears all bookkeeping immediately.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // A push coinciding with flush is discarded, so it must not touch storage either.
  pe_input_buffer_mem #(
    .BITWIDTH (BITWIDTH),
    .DEPTH    (DEPTH),
    .AW       (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q[PTR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[PTR_W-1:0]),
    .rdata (out_data)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef PE_INPUT_BUFFER_STATS_EN
  logic [31:0] accept_count_q, accept_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Accepted pushes wrap freely; dropped pushes saturate so a long stall stays visible.
  always_comb begin
    accept_count_d = accept_count_q;
    drop_count_d   = drop_count_q;
    if (flush) begin
      accept_count_d = '0;
      drop_count_d   = '0;
    end else begin
      if (push) begin
        accept_count_d = accept_count_q + 32'd1;
      end
      if (drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      accept_count_q <= '0;
      drop_count_q   <= '0;
    end else begin
      accept_count_q <= accept_count_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign accept_count = accept_count_q;
  assign drop_count   = drop_count_q;
`endif

endmodule
